bus_arbiter4: RTL and testbench

- Round-robin arbiter sharing the single system bus between four masters, e.g. instruction fetch, data port, DMA and debug.
- Produces a registered one-hot grant that drives the 4-bit select of the downstream 4:1 bus-data priority mux directly.
- Holds the grant for the owner's whole transaction and releases it on completion, on the owner dropping its request, or on a hold timeout.

---
 rtl/bus_arbiter4.sv | 98 +++++++++
 tb/tb_bus_arbiter4.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for one shared bus with four masters.
// Registered one-hot grant, hold-until-release, optional hold timeout.
module bus_arbiter4 #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] owner,
    output logic       bus_busy,
    output logic       timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [TW-1:0] LIMIT = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [TW-1:0] SAT   = TW'(TIMEOUT);

    state_t        state;
    logic [1:0]    last;
    logic [TW-1:0] cnt;

    // Returns {found, index}; the scan starts just above prev and wraps upward.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] prev);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = prev + 2'(k) + 2'd1;
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic       owner_req;
    logic       expire;
    logic       release_now;
    logic [2:0] idle_pick;
    logic [2:0] rel_pick;

    // The owner's own bit is already clear when it dropped its request, so a
    // plain re-pick from owner+1 covers the masking case.
    assign owner_req   = req[owner];
    assign expire      = (TIMEOUT != 0) && (cnt == LIMIT) && !done;
    assign release_now = done || !owner_req || expire;
    assign idle_pick   = pick(req, last);
    assign rel_pick    = pick(req, owner);

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 4'b0000;
            owner    <= 2'd0;
            bus_busy <= 1'b0;
            timeout  <= 1'b0;
            last     <= 2'd3;
            cnt      <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (idle_pick[2]) begin
                        grant    <= 4'b0001 << idle_pick[1:0];
                        owner    <= idle_pick[1:0];
                        bus_busy <= 1'b1;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        last    <= owner;
                        timeout <= expire;
                        cnt     <= '0;
                        if (rel_pick[2]) begin
                            grant <= 4'b0001 << rel_pick[1:0];
                            owner <= rel_pick[1:0];
                        end else begin
                            grant    <= 4'b0000;
                            owner    <= 2'd0;
                            bus_busy <= 1'b0;
                            state    <= IDLE;
                        end
                    end else if (cnt != SAT) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Self-checking bench for bus_arbiter4 (TIMEOUT=4): per-scenario tasks push
// expected outputs into a scoreboard queue and compare them after each edge.
module tb_bus_arbiter4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout;

    bus_arbiter4 #(.TIMEOUT(4), .TW(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .owner    (owner),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] o;
        logic       b;
        logic       t;
    } obs_t;

    typedef struct {
        logic       rst;
        logic [3:0] r;
        logic       d;
        obs_t       e;
    } stim_t;

    obs_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t mk(input logic [3:0] g, input logic [1:0] o, input logic t);
        return {g, o, |g, t};
    endfunction

    function automatic stim_t s(input logic rst, input logic [3:0] r, input logic d, input obs_t e);
        stim_t x;
        x.rst = rst; x.r = r; x.d = d; x.e = e;
        return x;
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after the edge.
    task automatic cyc(input stim_t st);
        reset = st.rst; req = st.r; done = st.d;
        sb.push_back(st.e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t st[$];
        obs_t  exp, act;
        st.push_back(s(1, 4'b1111, 0, mk(4'b0000, 0, 0)));
        st.push_back(s(1, 4'b1111, 0, mk(4'b0000, 0, 0)));
        st.push_back(s(0, 4'b1111, 0, mk(4'b0001, 0, 0)));
        st.push_back(s(0, 4'b0000, 0, mk(4'b0000, 0, 0)));
        foreach (st[i]) begin
            cyc(st[i]);
            exp = sb.pop_front();
            act = {grant, owner, bus_busy, timeout};
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL reset step %0d: got grant=%b owner=%0d busy=%b to=%b, want grant=%b owner=%0d busy=%b to=%b",
                         i, act.g, act.o, act.b, act.t, exp.g, exp.o, exp.b, exp.t);
            end
        end
    endtask

    task automatic test_rotation();
        stim_t st[$];
        obs_t  exp, act;
        logic [1:0] o;
        st.push_back(s(1, 4'b0000, 0, mk(4'b0000, 0, 0)));
        // Each owner keeps the bus for 3 cycles; done lands on its third cycle.
        for (int k = 1; k <= 13; k++) begin
            o = 2'(((k - 1) / 3) % 4);
            st.push_back(s(0, 4'b1111, (k >= 2) && ((k - 1) % 3 == 0), mk(4'b0001 << o, o, 0)));
        end
        st.push_back(s(0, 4'b0000, 0, mk(4'b0000, 0, 0)));
        foreach (st[i]) begin
            cyc(st[i]);
            exp = sb.pop_front();
            act = {grant, owner, bus_busy, timeout};
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL rotation step %0d: got grant=%b owner=%0d busy=%b to=%b, want grant=%b owner=%0d busy=%b to=%b",
                         i, act.g, act.o, act.b, act.t, exp.g, exp.o, exp.b, exp.t);
            end
        end
    endtask

    task automatic test_single();
        stim_t st[$];
        obs_t  exp, act;
        st.push_back(s(1, 4'b0000, 0, mk(4'b0000, 0, 0)));
        st.push_back(s(0, 4'b0100, 0, mk(4'b0100, 2, 0)));
        for (int k = 2; k <= 7; k++)
            st.push_back(s(0, 4'b0100, k % 2 == 1, mk(4'b0100, 2, 0)));
        st.push_back(s(0, 4'b0000, 0, mk(4'b0000, 0, 0)));
        st.push_back(s(0, 4'b0000, 0, mk(4'b0000, 0, 0)));
        foreach (st[i]) begin
            cyc(st[i]);
            exp = sb.pop_front();
            act = {grant, owner, bus_busy, timeout};
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL single step %0d: got grant=%b owner=%0d busy=%b to=%b, want grant=%b owner=%0d busy=%b to=%b",
                         i, act.g, act.o, act.b, act.t, exp.g, exp.o, exp.b, exp.t);
            end
        end
    endtask

    task automatic test_drop();
        stim_t st[$];
        obs_t  exp, act;
        st.push_back(s(1, 4'b0000, 0, mk(4'b0000, 0, 0)));
        st.push_back(s(0, 4'b0010, 0, mk(4'b0010, 1, 0)));
        st.push_back(s(0, 4'b1011, 0, mk(4'b0010, 1, 0)));  // no preemption
        st.push_back(s(0, 4'b1001, 0, mk(4'b1000, 3, 0)));  // owner 1 drops
        st.push_back(s(0, 4'b0000, 0, mk(4'b0000, 0, 0)));
        foreach (st[i]) begin
            cyc(st[i]);
            exp = sb.pop_front();
            act = {grant, owner, bus_busy, timeout};
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL drop step %0d: got grant=%b owner=%0d busy=%b to=%b, want grant=%b owner=%0d busy=%b to=%b",
                         i, act.g, act.o, act.b, act.t, exp.g, exp.o, exp.b, exp.t);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t st[$];
        obs_t  exp, act;
        st.push_back(s(1, 4'b0000, 0, mk(4'b0000, 0, 0)));
        st.push_back(s(0, 4'b0001, 0, mk(4'b0001, 0, 0)));
        for (int k = 0; k < 3; k++)
            st.push_back(s(0, 4'b0101, 0, mk(4'b0001, 0, 0)));
        st.push_back(s(0, 4'b0101, 0, mk(4'b0100, 2, 1)));  // forced release
        st.push_back(s(0, 4'b0101, 0, mk(4'b0100, 2, 0)));
        st.push_back(s(0, 4'b0101, 1, mk(4'b0001, 0, 0)));
        // Master 0 again; done arrives exactly on the expiry cycle.
        for (int k = 0; k < 3; k++)
            st.push_back(s(0, 4'b0101, 0, mk(4'b0001, 0, 0)));
        st.push_back(s(0, 4'b0101, 1, mk(4'b0100, 2, 0)));
        st.push_back(s(0, 4'b0000, 0, mk(4'b0000, 0, 0)));
        foreach (st[i]) begin
            cyc(st[i]);
            exp = sb.pop_front();
            act = {grant, owner, bus_busy, timeout};
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL timeout step %0d: got grant=%b owner=%0d busy=%b to=%b, want grant=%b owner=%0d busy=%b to=%b",
                         i, act.g, act.o, act.b, act.t, exp.g, exp.o, exp.b, exp.t);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t st[$];
        obs_t  exp, act;
        st.push_back(s(1, 4'b0000, 0, mk(4'b0000, 0, 0)));
        st.push_back(s(0, 4'b0010, 0, mk(4'b0010, 1, 0)));
        st.push_back(s(0, 4'b1000, 0, mk(4'b1000, 3, 0)));  // pointer now 1
        st.push_back(s(0, 4'b1000, 0, mk(4'b1000, 3, 0)));
        st.push_back(s(1, 4'b1000, 0, mk(4'b0000, 0, 0)));
        st.push_back(s(0, 4'b1001, 0, mk(4'b0001, 0, 0)));  // scan restarts at 0
        st.push_back(s(0, 4'b0000, 0, mk(4'b0000, 0, 0)));
        st.push_back(s(0, 4'b1000, 0, mk(4'b1000, 3, 0)));
        st.push_back(s(0, 4'b0000, 0, mk(4'b0000, 0, 0)));
        foreach (st[i]) begin
            cyc(st[i]);
            exp = sb.pop_front();
            act = {grant, owner, bus_busy, timeout};
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL reset_mid step %0d: got grant=%b owner=%0d busy=%b to=%b, want grant=%b owner=%0d busy=%b to=%b",
                         i, act.g, act.o, act.b, act.t, exp.g, exp.o, exp.b, exp.t);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        @(negedge clk);
        test_reset();
        test_rotation();
        test_single();
        test_drop();
        test_timeout();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
